// File: rtl/tone_arbiter.sv
// -----------------------------------------------------------------------------
// tone_arbiter
//   Shares one square-wave tone generator between three sound sources (game
//   tones, level-up melody, game-over alert). Each source posts a note
//   {freq, duration}. The arbiter grants the highest-index requester, drives its
//   frequency for exactly duration milliseconds, reports completion (or
//   pre-emption) with a one-cycle pulse and then holds a silent gap.
//
// Parameters
//   GAP_MS   silence in ms after every completed / aborted note (0 = no gap)
//   PREEMPT  1 = a higher-index pending request aborts the active note
//
// Ports
//   clk              in   1   system clock
//   rst_n            in   1   asynchronous reset, active low
//   ticks_per_milli  in  16   clock cycles per millisecond (>=1), static
//   req              in   3   request level per source, index 2 = highest
//   freq_in          in  30   packed note frequencies, source i at [10*i+9:10*i]
//   dur_in           in  30   packed note durations (ms), same packing
//   freq             out 10   frequency to play, 0 = silence
//   grant            out  3   one-hot, high while that source's note sounds
//   done             out  3   1-cycle pulse, note ran its full duration
//   aborted          out  3   1-cycle pulse, note was pre-empted
//   busy             out  1   high while a note or the gap is in progress
// -----------------------------------------------------------------------------

// Invariants on the registered outputs of the arbiter.
module tone_arbiter_chk (
  input logic       clk,
  input logic       rst_n,
  input logic [9:0] freq,
  input logic [2:0] grant,
  input logic [2:0] done,
  input logic [2:0] aborted,
  input logic       busy
);

  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(grant));

  a_done_xor_abort: assert property (@(posedge clk) disable iff (!rst_n)
    ((done & aborted) == 3'b000));

  a_freq_needs_grant: assert property (@(posedge clk) disable iff (!rst_n)
    ((freq != 10'd0) |-> (grant != 3'b000)));

  a_grant_needs_busy: assert property (@(posedge clk) disable iff (!rst_n)
    ((grant != 3'b000) |-> busy));

endmodule

module tone_arbiter #(
  parameter int GAP_MS  = 20,
  parameter bit PREEMPT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ticks_per_milli,
  input  logic [2:0]  req,
  input  logic [29:0] freq_in,
  input  logic [29:0] dur_in,
  output logic [9:0]  freq,
  output logic [2:0]  grant,
  output logic [2:0]  done,
  output logic [2:0]  aborted,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TONE = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Where a note goes once it ends: straight back to IDLE when no gap is wanted.
  localparam state_t     AFTER_NOTE = (GAP_MS > 0) ? ST_GAP : ST_IDLE;
  localparam logic       AFTER_BUSY = (GAP_MS > 0) ? 1'b1 : 1'b0;
  localparam logic [9:0] GAP_LAST   = (GAP_MS > 0) ? 10'(GAP_MS - 1) : 10'd0;

  // Index of the highest set request bit (caller guarantees req != 0).
  function automatic logic [1:0] top_index(input logic [2:0] r);
    logic [1:0] k;
    if (r[2]) begin
      k = 2'd2;
    end else if (r[1]) begin
      k = 2'd1;
    end else begin
      k = 2'd0;
    end
    return k;
  endfunction

  // One-hot vector for a source index.
  function automatic logic [2:0] onehot(input logic [1:0] k);
    logic [2:0] v;
    case (k)
      2'd0:    v = 3'b001;
      2'd1:    v = 3'b010;
      2'd2:    v = 3'b100;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

  // Sources that outrank source k.
  function automatic logic [2:0] above(input logic [1:0] k);
    logic [2:0] v;
    case (k)
      2'd0:    v = 3'b110;
      2'd1:    v = 3'b100;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

  // 10-bit field of source k from a packed 3x10 bus.
  function automatic logic [9:0] field10(input logic [29:0] bus, input logic [1:0] k);
    logic [9:0] f;
    case (k)
      2'd0:    f = bus[9:0];
      2'd1:    f = bus[19:10];
      2'd2:    f = bus[29:20];
      default: f = 10'd0;
    endcase
    return f;
  endfunction

  state_t      state_r, state_s;
  logic [15:0] pre_r, pre_s, pre_adv_s, tpm_last_s;
  logic [9:0]  ms_r, ms_s, ms_adv_s;
  logic [9:0]  dur_r, dur_s;
  logic [1:0]  src_r, src_s;
  logic [9:0]  freq_r, freq_s;
  logic [2:0]  grant_r, grant_s;
  logic [2:0]  done_r, done_s;
  logic [2:0]  aborted_r, aborted_s;
  logic        busy_r, busy_s;
  logic        tick_s;
  logic        finish_s;
  logic [1:0]  pick_s;
  logic [9:0]  pick_freq_s;
  logic [9:0]  pick_dur_s;

  // Millisecond timebase: prescaler wraps at ticks_per_milli-1 and bumps ms.
  assign tpm_last_s = ticks_per_milli - 16'd1;
  assign tick_s     = (pre_r == tpm_last_s);
  assign pre_adv_s  = tick_s ? 16'd0 : (pre_r + 16'd1);
  assign ms_adv_s   = tick_s ? (ms_r + 10'd1) : ms_r;

  // Arbitration candidate; only consumed in IDLE.
  assign pick_s      = top_index(req);
  assign pick_freq_s = field10(freq_in, pick_s);
  assign pick_dur_s  = field10(dur_in, pick_s);

  // Next-state and next-output logic for the IDLE/TONE/GAP sequencer.
  always_comb begin
    state_s   = state_r;
    pre_s     = pre_adv_s;
    ms_s      = ms_adv_s;
    dur_s     = dur_r;
    src_s     = src_r;
    freq_s    = freq_r;
    grant_s   = grant_r;
    done_s    = 3'b000;
    aborted_s = 3'b000;
    busy_s    = busy_r;
    finish_s  = 1'b0;

    case (state_r)
      ST_IDLE: begin
        pre_s   = 16'd0;
        ms_s    = 10'd0;
        grant_s = 3'b000;
        freq_s  = 10'd0;
        busy_s  = 1'b0;
        if (req != 3'b000) begin
          src_s = pick_s;
          dur_s = pick_dur_s;
          if (pick_dur_s == 10'd0) begin
            // Zero-length note: report completion without ever sounding.
            done_s   = onehot(pick_s);
            finish_s = 1'b1;
          end else begin
            state_s = ST_TONE;
            grant_s = onehot(pick_s);
            freq_s  = pick_freq_s;
            busy_s  = 1'b1;
          end
        end else begin
          src_s = src_r;
          dur_s = dur_r;
        end
      end

      ST_TONE: begin
        // Completion is tested first so it wins over a same-cycle pre-emption.
        if (tick_s && (ms_r == (dur_r - 10'd1))) begin
          done_s   = onehot(src_r);
          finish_s = 1'b1;
        end else if ((req & onehot(src_r)) == 3'b000) begin
          // Requester withdrew: silent end, no pulse.
          finish_s = 1'b1;
        end else if (PREEMPT && ((req & above(src_r)) != 3'b000)) begin
          aborted_s = onehot(src_r);
          finish_s  = 1'b1;
        end else begin
          finish_s = 1'b0;
        end
      end

      ST_GAP: begin
        grant_s = 3'b000;
        freq_s  = 10'd0;
        busy_s  = 1'b1;
        if (tick_s && (ms_r == GAP_LAST)) begin
          state_s = ST_IDLE;
          busy_s  = 1'b0;
          pre_s   = 16'd0;
          ms_s    = 10'd0;
        end else begin
          state_s = ST_GAP;
        end
      end

      default: begin
        state_s = ST_IDLE;
        pre_s   = 16'd0;
        ms_s    = 10'd0;
        grant_s = 3'b000;
        freq_s  = 10'd0;
        busy_s  = 1'b0;
      end
    endcase

    // Common note-end handling: silence, restart the timebase, enter the gap.
    state_s = finish_s ? AFTER_NOTE : state_s;
    busy_s  = finish_s ? AFTER_BUSY : busy_s;
    grant_s = finish_s ? 3'b000 : grant_s;
    freq_s  = finish_s ? 10'd0 : freq_s;
    pre_s   = finish_s ? 16'd0 : pre_s;
    ms_s    = finish_s ? 10'd0 : ms_s;
  end

  // State, timebase, latched note and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      pre_r     <= 16'd0;
      ms_r      <= 10'd0;
      dur_r     <= 10'd0;
      src_r     <= 2'd0;
      freq_r    <= 10'd0;
      grant_r   <= 3'b000;
      done_r    <= 3'b000;
      aborted_r <= 3'b000;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      pre_r     <= pre_s;
      ms_r      <= ms_s;
      dur_r     <= dur_s;
      src_r     <= src_s;
      freq_r    <= freq_s;
      grant_r   <= grant_s;
      done_r    <= done_s;
      aborted_r <= aborted_s;
      busy_r    <= busy_s;
    end
  end

  assign freq    = freq_r;
  assign grant   = grant_r;
  assign done    = done_r;
  assign aborted = aborted_r;
  assign busy    = busy_r;

  tone_arbiter_chk u_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .freq    (freq_r),
    .grant   (grant_r),
    .done    (done_r),
    .aborted (aborted_r),
    .busy    (busy_r)
  );

endmodule

// File: tb/tb_tone_arbiter.sv
// Bench for tone_arbiter: two instances (pre-emption on / off) with
// ticks_per_milli = 4 and a 2 ms gap, each compared every cycle against a
// cycle-countdown note model, plus hand-computed spot values.
module tb_tone_arbiter;

  localparam int TPM_I = 4;
  localparam int GAP_I = 2;

  logic        clk;
  logic        rst_n;
  logic [15:0] tpm;
  logic [2:0]  req_p, req_n;
  logic [9:0]  f_src [3];
  logic [9:0]  d_src [3];
  logic [29:0] freq_in_w, dur_in_w;

  logic [9:0] freq_p, freq_n;
  logic [2:0] grant_p, grant_n, done_p, done_n, ab_p, ab_n;
  logic       busy_p, busy_n;

  int n_pass;
  int n_total;

  assign freq_in_w = {f_src[2], f_src[1], f_src[0]};
  assign dur_in_w  = {d_src[2], d_src[1], d_src[0]};

  tone_arbiter #(.GAP_MS(GAP_I), .PREEMPT(1'b1)) dut_p (
    .clk(clk), .rst_n(rst_n), .ticks_per_milli(tpm), .req(req_p),
    .freq_in(freq_in_w), .dur_in(dur_in_w), .freq(freq_p), .grant(grant_p),
    .done(done_p), .aborted(ab_p), .busy(busy_p));

  tone_arbiter #(.GAP_MS(GAP_I), .PREEMPT(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .ticks_per_milli(tpm), .req(req_n),
    .freq_in(freq_in_w), .dur_in(dur_in_w), .freq(freq_n), .grant(grant_n),
    .done(done_n), .aborted(ab_n), .busy(busy_n));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: phase 0 idle, 1 sounding, 2 gap; 'left' counts remaining cycles.
  typedef struct packed {
    logic [1:0]  phase;
    logic [1:0]  k;
    logic [31:0] left;
    logic [9:0]  freq;
    logic [2:0]  grant;
    logic [2:0]  done;
    logic [2:0]  ab;
    logic        busy;
  } mstate_t;

  mstate_t m [2];

  function automatic mstate_t model_next(input mstate_t s, input logic pre_en, input logic [2:0] r);
    mstate_t n;
    int      hi;
    logic    fin;
    n = s;
    n.done = 3'b000;
    n.ab = 3'b000;
    fin = 1'b0;
    hi = 0;
    case (s.phase)
      2'd0: begin
        if (r != 3'b000) begin
          for (int i = 0; i < 3; i++) if (r[i]) hi = i;
          if (d_src[hi] == 10'd0) begin
            n.done = 3'b001 << hi;
            fin = 1'b1;
          end else begin
            n.phase = 2'd1;
            n.k = 2'(hi);
            n.left = 32'(d_src[hi]) * TPM_I;
            n.grant = 3'b001 << hi;
            n.freq = f_src[hi];
            n.busy = 1'b1;
          end
        end
      end
      2'd1: begin
        n.left = s.left - 32'd1;
        if (n.left == 32'd0) begin
          n.done = 3'b001 << s.k;
          fin = 1'b1;
        end else if (!r[s.k]) begin
          fin = 1'b1;
        end else if (pre_en && ((int'(r) >> (int'(s.k) + 1)) != 0)) begin
          n.ab = 3'b001 << s.k;
          fin = 1'b1;
        end
      end
      2'd2: begin
        n.left = s.left - 32'd1;
        if (n.left == 32'd0) begin
          n.phase = 2'd0;
          n.busy = 1'b0;
        end
      end
      default: n = '0;
    endcase
    if (fin) begin
      n.grant = 3'b000;
      n.freq = 10'd0;
      n.phase = 2'd2;
      n.busy = 1'b1;
      n.left = 32'(GAP_I * TPM_I);
    end
    return n;
  endfunction

  // Model state advance, reset asynchronously like the design.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m[0] <= '0;
      m[1] <= '0;
    end else begin
      m[0] <= model_next(m[0], 1'b1, req_p);
      m[1] <= model_next(m[1], 1'b0, req_n);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
  endtask

  task automatic compare_all();
    chk("p.freq", 32'(freq_p), 32'(m[0].freq));
    chk("p.grant", 32'(grant_p), 32'(m[0].grant));
    chk("p.done", 32'(done_p), 32'(m[0].done));
    chk("p.aborted", 32'(ab_p), 32'(m[0].ab));
    chk("p.busy", 32'(busy_p), 32'(m[0].busy));
    chk("n.freq", 32'(freq_n), 32'(m[1].freq));
    chk("n.grant", 32'(grant_n), 32'(m[1].grant));
    chk("n.done", 32'(done_n), 32'(m[1].done));
    chk("n.aborted", 32'(ab_n), 32'(m[1].ab));
    chk("n.busy", 32'(busy_n), 32'(m[1].busy));
    // Requesters drop their line during the done/aborted cycle.
    if ((m[0].done | m[0].ab) != 3'b000) req_p = req_p & ~(m[0].done | m[0].ab);
    if ((m[1].done | m[1].ab) != 3'b000) req_n = req_n & ~(m[1].done | m[1].ab);
  endtask

  task automatic wait_quiet();
    int cnt;
    cnt = 0;
    while (!((m[0].phase == 2'd0) && (m[1].phase == 2'd0) && (req_p == 3'b000) &&
             (req_n == 3'b000)) && (cnt < 400)) begin
      @(negedge clk);
      cnt++;
    end
    chk("quiet_bound", 32'(cnt < 400), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int g_cnt, b_cnt, d_cnt;
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b1;
    tpm = 16'd4;
    req_p = 3'b000;
    req_n = 3'b000;
    for (int i = 0; i < 3; i++) begin
      f_src[i] = 10'd0;
      d_src[i] = 10'd0;
    end
    fork
      forever begin
        @(negedge clk);
        compare_all();
      end
    join_none

    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst.freq", 32'(freq_p), 32'd0);
    chk("rst.grant", 32'(grant_p), 32'd0);
    chk("rst.busy", 32'(busy_n), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single note, 3 ms at 4 ticks/ms, then 2 ms gap.
    f_src[0] = 10'd196; d_src[0] = 10'd3;
    req_p = 3'b001; req_n = 3'b001;
    g_cnt = 0; b_cnt = 0; d_cnt = 0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (i == 1) chk("t1.freq", 32'(freq_p), 32'd196);
      if (grant_p == 3'b001) g_cnt++;
      if (busy_p) b_cnt++;
      if (done_p == 3'b001) d_cnt++;
    end
    chk("t1.grant_cycles", 32'(g_cnt), 32'd12);
    chk("t1.busy_cycles", 32'(b_cnt), 32'd20);
    chk("t1.done_pulses", 32'(d_cnt), 32'd1);
    wait_quiet();

    // 2: sources 0 and 1 together; 1 first, 0 after gap + one idle cycle.
    f_src[1] = 10'd262; d_src[1] = 10'd2;
    req_p = 3'b011; req_n = 3'b011;
    @(negedge clk);
    chk("t2.grant1", 32'(grant_p), 32'b010);
    chk("t2.freq1", 32'(freq_p), 32'd262);
    repeat (8) @(negedge clk);
    chk("t2.done1", 32'(done_p), 32'b010);
    repeat (8) @(negedge clk);
    chk("t2.idle_busy", 32'(busy_p), 32'd0);
    @(negedge clk);
    chk("t2.grant0", 32'(grant_p), 32'b001);
    chk("t2.freq0", 32'(freq_p), 32'd196);
    wait_quiet();

    // 3/4: source 2 arrives during a 10 ms note of source 0.
    f_src[0] = 10'd330; d_src[0] = 10'd10;
    f_src[2] = 10'd523; d_src[2] = 10'd1;
    req_p = 3'b001; req_n = 3'b001;
    repeat (5) @(negedge clk);
    req_p[2] = 1'b1; req_n[2] = 1'b1;
    @(negedge clk);
    chk("t3.aborted", 32'(ab_p), 32'b001);
    chk("t3.freq_gap", 32'(freq_p), 32'd0);
    chk("t4.still_on", 32'(freq_n), 32'd330);
    repeat (9) @(negedge clk);
    chk("t3.grant2", 32'(grant_p), 32'b100);
    chk("t3.freq2", 32'(freq_p), 32'd523);
    repeat (26) @(negedge clk);
    chk("t4.done0", 32'(done_n), 32'b001);
    chk("t4.no_abort", 32'(ab_n), 32'd0);
    repeat (9) @(negedge clk);
    chk("t4.grant2", 32'(grant_n), 32'b100);
    wait_quiet();

    // 5: zero-duration note.
    f_src[1] = 10'd440; d_src[1] = 10'd0;
    req_p = 3'b010; req_n = 3'b010;
    @(negedge clk);
    chk("t5.done", 32'(done_p), 32'b010);
    chk("t5.freq", 32'(freq_p), 32'd0);
    chk("t5.busy", 32'(busy_p), 32'd1);
    wait_quiet();

    // Last-cycle pre-emption: completion wins.
    f_src[0] = 10'd300; d_src[0] = 10'd2;
    f_src[2] = 10'd500; d_src[2] = 10'd1;
    req_p = 3'b001;
    repeat (8) @(negedge clk);
    req_p[2] = 1'b1;
    @(negedge clk);
    chk("tie.done", 32'(done_p), 32'b001);
    chk("tie.aborted", 32'(ab_p), 32'd0);
    wait_quiet();

    // Withdrawal mid-note.
    d_src[0] = 10'd5;
    req_p = 3'b001;
    repeat (3) @(negedge clk);
    req_p[0] = 1'b0;
    @(negedge clk);
    chk("wd.grant", 32'(grant_p), 32'd0);
    chk("wd.done", 32'(done_p), 32'd0);
    chk("wd.busy", 32'(busy_p), 32'd1);
    wait_quiet();

    // Lower-priority request never aborts.
    f_src[2] = 10'd600; d_src[2] = 10'd2;
    req_p = 3'b100;
    repeat (2) @(negedge clk);
    req_p[0] = 1'b1;
    repeat (7) @(negedge clk);
    chk("lo.done2", 32'(done_p), 32'b100);
    wait_quiet();

    // 6: asynchronous reset between edges during a note.
    f_src[0] = 10'd196; d_src[0] = 10'd5;
    req_p = 3'b001; req_n = 3'b001;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6.freq", 32'(freq_p), 32'd0);
    chk("t6.grant", 32'(grant_n), 32'd0);
    chk("t6.busy", 32'(busy_p), 32'd0);
    req_p = 3'b000; req_n = 3'b000;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6.no_done", 32'(done_p), 32'd0);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
